// File: rtl/sid_pkg.sv
// Shared types and default pass lengths for the SID cycle sequencer and write scheduler.
// Cycle values use 0 to mean idle.
package sid;

  localparam int VOICE_LAST_DEFAULT  = 18;
  localparam int FILTER_LAST_DEFAULT = 12;
  localparam int REPLAY_LAST         = 6;

  typedef logic [4:0] cycle_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOICE  = 2'd1,
    FILTER = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [1:0] cs;
    logic [4:0] addr;
    logic [7:0] data;
  } wr_req_t;

endpackage

// File: rtl/sid_bus_capture.sv
// Detects CPU writes on the falling phi2 edge and holds one pending request; the request is
// visible one clock after the edge, and an unconsumed request is overwritten with a drop pulse.
module sid_bus_capture
  import sid::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_phi2_i,
  input  logic       bus_r_w_n_i,
  input  logic [1:0] bus_cs_i,
  input  logic [4:0] bus_addr_i,
  input  logic [7:0] bus_data_i,
  input  logic       take_i,
  output logic       pend_vld_o,
  output wr_req_t    pend_o,
  output logic       drop_o
);

  logic    phi2_prev_q;
  logic    pend_vld_q, pend_vld_d;
  wr_req_t pend_q, pend_d;
  logic    drop_q, drop_d;
  logic    wr_detect;

  assign wr_detect = phi2_prev_q & ~bus_phi2_i & ~bus_r_w_n_i & (|bus_cs_i);

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = 1'b0;
    if (take_i) begin
      pend_vld_d = 1'b0;
    end
    // A take on the same edge hands the old entry to the scheduler, so nothing is lost then.
    if (wr_detect) begin
      pend_d.cs   = bus_cs_i;
      pend_d.addr = bus_addr_i;
      pend_d.data = bus_data_i;
      pend_vld_d  = 1'b1;
      drop_d      = pend_vld_q & ~take_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi2_prev_q <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      drop_q      <= 1'b0;
    end else begin
      phi2_prev_q <= bus_phi2_i;
      pend_vld_q  <= pend_vld_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
    end
  end

  assign pend_vld_o = pend_vld_q;
  assign pend_o     = pend_q;
  assign drop_o     = drop_q;

endmodule

// File: rtl/sid_cycle_sched.sv
// Per-sample voice/filter cycle sequencer that replays one captured write in voice cycles 1..6.
// Optional SID_SCHED_STATS_EN adds saturating drop/overrun counters.
module sid_cycle_sched
  import sid::*;
#(
  parameter int VOICE_LAST  = VOICE_LAST_DEFAULT,
  parameter int FILTER_LAST = FILTER_LAST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        bus_phi2,
  input  logic        bus_r_w_n,
  input  logic [1:0]  bus_cs,
  input  logic [4:0]  bus_addr,
  input  logic [7:0]  bus_data,
  output logic [4:0]  voice_cycle,
  output logic [4:0]  filter_cycle,
  output logic        busy,
  output logic        wr_en,
  output logic [1:0]  wr_cs,
  output logic [4:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_drop,
  output logic        overrun
`ifdef SID_SCHED_STATS_EN
  ,
  output logic [15:0] drop_count,
  output logic [15:0] overrun_count
`endif
);

  localparam cycle_t VLAST  = cycle_t'(VOICE_LAST);
  localparam cycle_t FLAST  = cycle_t'(FILTER_LAST);
  localparam cycle_t RLAST  = cycle_t'(REPLAY_LAST);
  localparam cycle_t CYC_1  = cycle_t'(1);

  sched_state_t state_q, state_d;
  cycle_t       voice_q, voice_d;
  cycle_t       filter_q, filter_d;
  logic         take;

  logic         act_vld_q, act_vld_d;
  wr_req_t      act_q, act_d;
  logic         wr_en_q, wr_en_d;
  wr_req_t      wr_q, wr_d;
  logic         replay;

  logic         pend_vld;
  wr_req_t      pend;
  logic         drop_pulse;

  sid_bus_capture u_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_phi2_i  (bus_phi2),
    .bus_r_w_n_i (bus_r_w_n),
    .bus_cs_i    (bus_cs),
    .bus_addr_i  (bus_addr),
    .bus_data_i  (bus_data),
    .take_i      (take),
    .pend_vld_o  (pend_vld),
    .pend_o      (pend),
    .drop_o      (drop_pulse)
  );

  always_comb begin
    state_d  = state_q;
    voice_d  = voice_q;
    filter_d = filter_q;
    take     = 1'b0;
    unique case (state_q)
      IDLE: begin
        voice_d  = '0;
        filter_d = '0;
        if (start) begin
          state_d = VOICE;
          voice_d = CYC_1;
          take    = 1'b1;
        end
      end
      VOICE: begin
        if (voice_q == VLAST) begin
          state_d  = FILTER;
          voice_d  = '0;
          filter_d = CYC_1;
        end else begin
          voice_d = voice_q + CYC_1;
        end
      end
      FILTER: begin
        if (filter_q == FLAST) begin
          state_d  = IDLE;
          filter_d = '0;
        end else begin
          filter_d = filter_q + CYC_1;
        end
      end
      default: begin
        state_d  = IDLE;
        voice_d  = '0;
        filter_d = '0;
      end
    endcase
  end

  // The active slot is only loaded when a pass begins, so writes seen mid-pass wait for the next one.
  always_comb begin
    act_vld_d = act_vld_q;
    act_d     = act_q;
    if (take) begin
      act_vld_d = pend_vld;
      act_d     = pend;
    end else if (voice_q == RLAST) begin
      act_vld_d = 1'b0;
    end
    replay  = act_vld_d && (voice_d >= CYC_1) && (voice_d <= RLAST);
    wr_en_d = replay;
    wr_d    = replay ? act_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      voice_q   <= '0;
      filter_q  <= '0;
      act_vld_q <= 1'b0;
      act_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_q      <= '0;
    end else begin
      state_q   <= state_d;
      voice_q   <= voice_d;
      filter_q  <= filter_d;
      act_vld_q <= act_vld_d;
      act_q     <= act_d;
      wr_en_q   <= wr_en_d;
      wr_q      <= wr_d;
    end
  end

  assign voice_cycle  = voice_q;
  assign filter_cycle = filter_q;
  assign busy         = (state_q != IDLE);
  assign wr_en        = wr_en_q;
  assign wr_cs        = wr_q.cs;
  assign wr_addr      = wr_q.addr;
  assign wr_data      = wr_q.data;
  assign wr_drop      = drop_pulse;
  // The last filter cycle still reads as busy, so a start there is rejected too.
  assign overrun      = start & busy;

`ifdef SID_SCHED_STATS_EN
  logic [15:0] drop_cnt_q, ovr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      ovr_cnt_q  <= '0;
    end else begin
      if (wr_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (overrun && (ovr_cnt_q != 16'hFFFF))  ovr_cnt_q  <= ovr_cnt_q + 16'd1;
    end
  end

  assign drop_count    = drop_cnt_q;
  assign overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_sid_cycle_sched.sv
// Bench for sid_cycle_sched: directed table, multi-cycle corner sequences and random traffic
// checked against a pass-position reference model.
module tb_sid_cycle_sched;

  localparam int VL   = 18;
  localparam int FL   = 12;
  localparam int PASS = VL + FL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       bus_phi2;
  logic       bus_r_w_n;
  logic [1:0] bus_cs;
  logic [4:0] bus_addr;
  logic [7:0] bus_data;
  logic [4:0] voice_cycle;
  logic [4:0] filter_cycle;
  logic       busy;
  logic       wr_en;
  logic [1:0] wr_cs;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_drop;
  logic       overrun;
`ifdef SID_SCHED_STATS_EN
  logic [15:0] drop_count;
  logic [15:0] overrun_count;
`endif

  sid_cycle_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus_phi2     (bus_phi2),
    .bus_r_w_n    (bus_r_w_n),
    .bus_cs       (bus_cs),
    .bus_addr     (bus_addr),
    .bus_data     (bus_data),
    .voice_cycle  (voice_cycle),
    .filter_cycle (filter_cycle),
    .busy         (busy),
    .wr_en        (wr_en),
    .wr_cs        (wr_cs),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_drop      (wr_drop),
    .overrun      (overrun)
`ifdef SID_SCHED_STATS_EN
    ,
    .drop_count   (drop_count),
    .overrun_count(overrun_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: position within the pass (0 = idle, 1..PASS), one pending and one active request.
  int          m_p;
  bit          m_prev;
  bit          m_pv;
  logic [14:0] m_pend;
  bit          m_av;
  logic [14:0] m_act;
  bit          m_drop;

  int          t_busy, t_wr, t_drop, t_ovr, t_maxv, t_maxf;
  logic [14:0] t_last_wr;

  typedef struct {
    bit         s;
    bit         p;
    bit         rw;
    logic [1:0] cs;
    logic [4:0] a;
    logic [7:0] d;
    logic [4:0] ev;
    bit         een;
    logic [1:0] ecs;
    logic [4:0] ea;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_prev = 0; m_pv = 0; m_pend = '0; m_av = 0; m_act = '0; m_drop = 0;
  endtask

  task automatic clear_tally();
    t_busy = 0; t_wr = 0; t_drop = 0; t_ovr = 0; t_maxv = 0; t_maxf = 0; t_last_wr = '0;
  endtask

  task automatic check_outputs();
    int ev, ef;
    ev = (m_p >= 1 && m_p <= VL) ? m_p : 0;
    ef = (m_p > VL) ? m_p - VL : 0;
    chk("voice_cycle", 32'(voice_cycle), ev);
    chk("filter_cycle", 32'(filter_cycle), ef);
    chk("busy", 32'(busy), 32'(m_p != 0));
    chk("wr_en", 32'(wr_en), 32'(m_av));
    chk("wr_req", 32'({wr_cs, wr_addr, wr_data}), m_av ? 32'(m_act) : 32'd0);
    chk("wr_drop", 32'(wr_drop), 32'(m_drop));
    chk("overrun", 32'(overrun), 32'(start && (m_p != 0)));
    if (busy) t_busy++;
    if (wr_en) begin
      t_wr++;
      t_last_wr = {wr_cs, wr_addr, wr_data};
    end
    if (wr_drop) t_drop++;
    if (overrun) t_ovr++;
    if (int'(voice_cycle) > t_maxv) t_maxv = int'(voice_cycle);
    if (int'(filter_cycle) > t_maxf) t_maxf = int'(filter_cycle);
  endtask

  task automatic model_edge();
    bit take, det;
    if (!rst_n) begin
      model_reset();
    end else begin
      take   = (m_p == 0) && start;
      det    = m_prev && !bus_phi2 && !bus_r_w_n && (bus_cs != 2'b00);
      m_drop = det && m_pv && !take;
      if (take) begin
        m_av = m_pv;
        m_act = m_pend;
        m_pv = 0;
      end
      if (det) begin
        m_pv = 1;
        m_pend = {bus_cs, bus_addr, bus_data};
      end
      if (m_p == 0) m_p = take ? 1 : 0;
      else m_p = (m_p == PASS) ? 0 : m_p + 1;
      if (m_p < 1 || m_p > 6) m_av = 0;
      m_prev = bus_phi2;
    end
  endtask

  task automatic drive(input bit s, input bit p, input bit rw, input logic [1:0] cs,
                       input logic [4:0] a, input logic [7:0] d);
    start = s; bus_phi2 = p; bus_r_w_n = rw; bus_cs = cs; bus_addr = a; bus_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input bit s, input bit p, input bit rw, input logic [1:0] cs,
                      input logic [4:0] a, input logic [7:0] d);
    drive(s, p, rw, cs, a, d);
    #1;
    check_outputs();
    tick();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 8'd0);
  endtask

  task automatic start_step();
    step(1'b1, 1'b0, 1'b1, 2'b00, 5'd0, 8'd0);
  endtask

  task automatic do_write(input logic [1:0] cs, input logic [4:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, cs, a, d);
    step(1'b0, 1'b0, 1'b0, cs, a, d);
    idle_step();
  endtask

  task automatic wait_voice(input int v, input int limit);
    int n = 0;
    while (int'(voice_cycle) != v && n < limit) begin
      idle_step();
      n++;
    end
    chk("wait_voice", 32'(voice_cycle), v);
  endtask

  task automatic wait_filter(input int v, input int limit);
    int n = 0;
    while (int'(filter_cycle) != v && n < limit) begin
      idle_step();
      n++;
    end
    chk("wait_filter", 32'(filter_cycle), v);
  endtask

  task automatic run_to_idle(input int limit);
    int n = 0;
    #1;
    while (busy && n < limit) begin
      idle_step();
      n++;
    end
    chk("reach_idle", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 8'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            s  p  rw cs     a      d      ev   een ecs    ea     ed
    tbl[0]  = '{0, 1, 0, 2'b01, 5'h04, 8'h41, 5'd0, 0, 2'b00, 5'h00, 8'h00};
    tbl[1]  = '{0, 0, 0, 2'b01, 5'h04, 8'h41, 5'd0, 0, 2'b00, 5'h00, 8'h00};
    tbl[2]  = '{1, 0, 1, 2'b00, 5'h00, 8'h00, 5'd0, 0, 2'b00, 5'h00, 8'h00};
    tbl[3]  = '{0, 0, 1, 2'b00, 5'h00, 8'h00, 5'd1, 1, 2'b01, 5'h04, 8'h41};
    tbl[4]  = '{0, 0, 1, 2'b00, 5'h00, 8'h00, 5'd2, 1, 2'b01, 5'h04, 8'h41};
    tbl[5]  = '{0, 0, 1, 2'b00, 5'h00, 8'h00, 5'd3, 1, 2'b01, 5'h04, 8'h41};
    tbl[6]  = '{0, 0, 1, 2'b00, 5'h00, 8'h00, 5'd4, 1, 2'b01, 5'h04, 8'h41};
    tbl[7]  = '{0, 0, 1, 2'b00, 5'h00, 8'h00, 5'd5, 1, 2'b01, 5'h04, 8'h41};
    tbl[8]  = '{0, 0, 1, 2'b00, 5'h00, 8'h00, 5'd6, 1, 2'b01, 5'h04, 8'h41};
    tbl[9]  = '{0, 0, 1, 2'b00, 5'h00, 8'h00, 5'd7, 0, 2'b00, 5'h00, 8'h00};
    tbl[10] = '{0, 0, 1, 2'b00, 5'h00, 8'h00, 5'd8, 0, 2'b00, 5'h00, 8'h00};

    clear_tally();
    do_reset();

    // Directed write at idle then a pass; the first row also covers the reset state.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].rw, tbl[i].cs, tbl[i].a, tbl[i].d);
      #1;
      chk($sformatf("tbl%0d_voice", i), 32'(voice_cycle), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].een));
      chk($sformatf("tbl%0d_wr_req", i), 32'({wr_cs, wr_addr, wr_data}),
          32'({tbl[i].ecs, tbl[i].ea, tbl[i].ed}));
      check_outputs();
      tick();
    end
    run_to_idle(100);

    // Plain pass: 30 busy cycles, full counter ranges, no replay.
    clear_tally();
    start_step();
    run_to_idle(100);
    chk("pass_busy_cycles", t_busy, 30);
    chk("pass_max_voice", t_maxv, 18);
    chk("pass_max_filter", t_maxf, 12);
    chk("pass_no_replay", t_wr, 0);

    // Two writes before start: one drop, only the second is replayed.
    clear_tally();
    do_write(2'b01, 5'h10, 8'hAA);
    do_write(2'b01, 5'h11, 8'h55);
    start_step();
    run_to_idle(100);
    chk("dbl_drop_pulses", t_drop, 1);
    chk("dbl_wr_cycles", t_wr, 6);
    chk("dbl_wr_req", 32'(t_last_wr), 32'({2'b01, 5'h11, 8'h55}));

    // Write landing in voice cycle 3 waits for the next pass.
    clear_tally();
    start_step();
    wait_voice(2, 50);
    do_write(2'b10, 5'h1F, 8'h33);
    run_to_idle(100);
    chk("midpass_no_wr", t_wr, 0);
    clear_tally();
    start_step();
    run_to_idle(100);
    chk("nextpass_wr_cycles", t_wr, 6);
    chk("nextpass_wr_req", 32'(t_last_wr), 32'({2'b10, 5'h1F, 8'h33}));

    // Start during filter cycle 5: overrun once, pass length unchanged.
    clear_tally();
    start_step();
    wait_filter(5, 50);
    start_step();
    run_to_idle(100);
    chk("ovr_pulses", t_ovr, 1);
    chk("ovr_busy_cycles", t_busy, 30);

    // Start on the final filter cycle also counts as busy.
    clear_tally();
    start_step();
    wait_filter(12, 50);
    start_step();
    #1;
    chk("last_cycle_ovr", t_ovr, 1);
    chk("last_cycle_idle", 32'(busy), 0);

    // Reset mid-replay clears everything asynchronously; no replay afterwards.
    do_write(2'b01, 5'h07, 8'h99);
    start_step();
    wait_voice(4, 50);
    chk("prereset_wr_en", 32'(wr_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs",
        32'({voice_cycle, filter_cycle, busy, wr_en, wr_cs, wr_addr, wr_data, wr_drop, overrun}), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_tally();
    start_step();
    run_to_idle(100);
    chk("postreset_no_wr", t_wr, 0);

    // Random bus and start traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
